// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state type, bus widths and the request error check.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic addr_err(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] depth_words
    );
        logic [ADDR_W-1:0] word;
        word = {2'b00, addr[ADDR_W-1:2]};
        return (addr[1:0] != 2'b00) || (word >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with a byte-enabled write port.
// One enable pulse either writes the enabled lanes or registers a read.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Single access per enable: lane-masked store or registered load.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage load/store port.
// Accepts one request, waits WAIT_STATES cycles, then responds once.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_stall
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t state;
    state_t next_state;

    logic [3:0]        cnt;
    logic              wr_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              accept;
    logic              req_err;
    logic              cur_wr;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              arr_en;
    logic [DATA_W-1:0] arr_rdata;

    assign accept  = (state == IDLE) && req_valid;
    assign req_err = addr_err(req_addr, ADDR_W'(DEPTH_WORDS));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request at acceptance and run the wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            cnt     <= 4'(WAIT_STATES);
            wr_q    <= req_write;
            err_q   <= req_err;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_stall  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_stall = req_valid;
                if (req_valid) begin
                    next_state = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (cnt <= 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // With zero wait states the commit happens straight from IDLE,
    // before the capture registers load, so use the live request then.
    always_comb begin
        cur_wr    = wr_q;
        cur_err   = err_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state == IDLE) begin
            cur_wr    = req_write;
            cur_err   = req_err;
            cur_idx   = req_addr[IDX_W+1:2];
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
        arr_en = !reset && (next_state == RESP) && !cur_err;
    end

    // Response data: loads only; stores and errors return zero.
    always_comb begin
        resp_rdata = '0;
        resp_err   = resp_valid && err_q;
        if (resp_valid && !wr_q && !err_q) begin
            resp_rdata = arr_rdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock (clock),
        .en    (arr_en),
        .we    (cur_wr),
        .be    (cur_be),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Table-driven requests with a scoreboard, plus reset and zero-wait cases.
module tb_dmem_responder;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_stall;

    logic        z_req_valid = 1'b0;
    logic        z_req_write = 1'b0;
    logic [31:0] z_req_addr  = '0;
    logic [31:0] z_req_wdata = '0;
    logic [3:0]  z_req_be    = '0;
    logic        z_req_ready;
    logic        z_resp_valid;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;
    logic        z_mem_stall;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_stall  (mem_stall)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_write  (z_req_write),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_be     (z_req_be),
        .req_ready  (z_req_ready),
        .resp_valid (z_resp_valid),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err),
        .mem_stall  (z_mem_stall)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    sb_t  sb[$];
    logic prev_rv = 1'b0;
    vec_t tbl[21];
    vec_t ztbl[4];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every response is matched against the oldest request.
    always @(negedge clock) begin
        sb_t e;
        if (resp_valid) begin
            chk("no_adjacent_resp", 32'(prev_rv), 32'd0);
            chk("resp_stall_low", 32'(mem_stall), 32'd0);
            chk("resp_ready_low", 32'(req_ready), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got response, expected none");
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("latency", 32'(cyc - e.acc), 32'd3);
            end
        end
        prev_rv = resp_valid;
    end

    task automatic do_req(input vec_t v);
        int n = 0;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        chk("accept_stall", 32'(mem_stall), 32'd1);
        if (req_ready) sb.push_back('{v.exp_rdata, v.exp_err, cyc});
        @(negedge clock);
        req_valid = 1'b0;
        req_wdata = 32'hXXXX_XXXX;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic z_store(input logic [31:0] a, input logic [31:0] d);
        z_req_write = 1'b1;
        z_req_addr  = a;
        z_req_wdata = d;
        z_req_be    = 4'hF;
        z_req_valid = 1'b1;
        #1;
        chk("z_st_stall", 32'(z_mem_stall), 32'd1);
        @(negedge clock);
        chk("z_st_resp", 32'(z_resp_valid), 32'd1);
        chk("z_st_err", 32'(z_resp_err), 32'd0);
        z_req_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 32'h000, 32'h1111_1111, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'h010, 32'h0000_00AA, 4'h1, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
        tbl[5]  = '{1'b0, 32'h013, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[6]  = '{1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 32'h013, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        tbl[8]  = '{1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        tbl[9]  = '{1'b0, 32'h010, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
        tbl[10] = '{1'b0, 32'h000, 32'h0, 4'h0, 32'h1111_1111, 1'b0};
        tbl[11] = '{1'b1, 32'h024, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0};
        tbl[12] = '{1'b1, 32'h024, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 32'h024, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0};
        tbl[14] = '{1'b1, 32'h3FC, 32'h0123_4567, 4'hF, 32'h0, 1'b0};
        tbl[15] = '{1'b1, 32'h3FC, 32'hA5A5_A5A5, 4'hA, 32'h0, 1'b0};
        tbl[16] = '{1'b0, 32'h3FC, 32'h0, 4'h0, 32'hA523_A567, 1'b0};
        tbl[17] = '{1'b0, 32'h402, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[18] = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[19] = '{1'b1, 32'h020, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
        tbl[20] = '{1'b0, 32'h020, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};

        ztbl[0] = '{1'b0, 32'h000, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b0};
        ztbl[1] = '{1'b0, 32'h004, 32'h0, 4'h0, 32'h1122_3344, 1'b0};
        ztbl[2] = '{1'b0, 32'h013, 32'h0, 4'h0, 32'h0, 1'b1};
        ztbl[3] = '{1'b0, 32'h000, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b0};

        // Reset defaults.
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_z_ready", 32'(z_req_ready), 32'd1);
        chk("rst_z_stall", 32'(z_mem_stall), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven requests, WAIT_STATES=2.
        for (int i = 0; i < 21; i++) do_req(tbl[i]);
        drain();

        // Reset during WAIT aborts the store; load right after release.
        req_write = 1'b1;
        req_addr  = 32'h020;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        req_valid = 1'b1;
        #1;
        chk("abort_accept_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        chk("abort_wait_stall", 32'(mem_stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_rst_ready", 32'(req_ready), 32'd1);
        chk("abort_rst_stall", 32'(mem_stall), 32'd0);
        @(negedge clock);
        @(negedge clock);
        req_write = 1'b0;
        req_addr  = 32'h020;
        req_valid = 1'b1;
        sb.push_back('{32'hCAFE_F00D, 1'b0, cyc});
        reset = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        drain();

        // Reset after the commit edge keeps the stored word.
        do_req('{1'b1, 32'h028, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0});
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("commit_resp_seen", 32'(resp_valid), 32'd1);
        #2;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_req('{1'b0, 32'h028, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0});
        drain();

        // Zero wait states, back-to-back loads with req_valid held.
        z_store(32'h000, 32'h0A0B_0C0D);
        z_store(32'h004, 32'h1122_3344);
        z_req_write = 1'b0;
        z_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) z_req_addr = ztbl[i/2].addr;
            #1;
            chk("z_stall", 32'(z_mem_stall), 32'(i % 2 == 0));
            chk("z_resp_valid", 32'(z_resp_valid), 32'(i % 2 == 1));
            if (i % 2 == 1) begin
                chk("z_rdata", z_resp_rdata, ztbl[i/2].exp_rdata);
                chk("z_err", 32'(z_resp_err), 32'(ztbl[i/2].exp_err));
            end
            @(negedge clock);
        end
        z_req_valid = 1'b0;
        @(negedge clock);
        #1;
        chk("z_idle_ready", 32'(z_req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
